// File: rtl/bus_arbiter.sv
// Two-master arbiter for the word-addressed system bus with per-transaction timeout.
// Build option: define ARB_ROUND_ROBIN_EN for alternating priority; default is fixed m1 priority.
module bus_arbiter #(
  parameter int unsigned TO_CYCLES = 255,
  parameter int unsigned TO_WIDTH  = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        m0_stb,
  input  logic        m0_we,
  input  logic [21:0] m0_addr,
  input  logic [31:0] m0_dout,
  output logic [31:0] m0_din,
  output logic        m0_ack,
  input  logic        m1_stb,
  input  logic        m1_we,
  input  logic [21:0] m1_addr,
  input  logic [31:0] m1_dout,
  output logic [31:0] m1_din,
  output logic        m1_ack,
  output logic        bus_stb,
  output logic        bus_we,
  output logic [21:0] bus_addr,
  output logic [31:0] bus_dout,
  input  logic [31:0] bus_din,
  input  logic        bus_ack,
  output logic        bus_err
);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t              state, state_nxt;
  logic [TO_WIDTH-1:0] to_cnt, to_cnt_nxt;
  logic                last_gnt, last_gnt_nxt;  // 1 = m1 was granted last

  logic        sel_m1;
  logic        g_stb;
  logic        g_we;
  logic [21:0] g_addr;
  logic [31:0] g_dout;
  logic        expired;
  logic        m1_wins;
  logic        t_ack;
  logic [31:0] t_din;

  assign sel_m1  = (state == GNT1);
  assign g_stb   = sel_m1 ? m1_stb  : m0_stb;
  assign g_we    = sel_m1 ? m1_we   : m0_we;
  assign g_addr  = sel_m1 ? m1_addr : m0_addr;
  assign g_dout  = sel_m1 ? m1_dout : m0_dout;
  assign expired = (to_cnt == TO_WIDTH'(TO_CYCLES - 1));

`ifdef ARB_ROUND_ROBIN_EN
  assign m1_wins = ~last_gnt;
`else
  assign m1_wins = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      to_cnt   <= '0;
      last_gnt <= 1'b1;
    end else begin
      state    <= state_nxt;
      to_cnt   <= to_cnt_nxt;
      last_gnt <= last_gnt_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    to_cnt_nxt   = to_cnt;
    last_gnt_nxt = last_gnt;
    bus_stb      = 1'b0;
    bus_we       = 1'b0;
    bus_addr     = '0;
    bus_dout     = '0;
    bus_err      = 1'b0;
    t_ack        = 1'b0;
    t_din        = '0;

    case (state)
      IDLE: begin
        to_cnt_nxt = '0;
        if (m1_stb && (!m0_stb || m1_wins)) begin
          state_nxt = GNT1;
        end else if (m0_stb) begin
          state_nxt = GNT0;
        end
      end

      GNT0, GNT1: begin
        bus_stb  = g_stb;
        bus_we   = g_we;
        bus_addr = g_addr;
        bus_dout = g_dout;
        // Ack is tested before expiry so a late-but-valid ack is never turned into an error.
        if (!g_stb) begin
          state_nxt  = IDLE;
          to_cnt_nxt = '0;
        end else if (bus_ack) begin
          t_ack        = 1'b1;
          t_din        = bus_din;
          state_nxt    = IDLE;
          to_cnt_nxt   = '0;
          last_gnt_nxt = sel_m1;
        end else if (expired) begin
          t_ack        = 1'b1;
          t_din        = '1;
          bus_err      = 1'b1;
          state_nxt    = IDLE;
          to_cnt_nxt   = '0;
          last_gnt_nxt = sel_m1;
        end else begin
          to_cnt_nxt = to_cnt + TO_WIDTH'(1);
        end
      end

      default: begin
        state_nxt  = IDLE;
        to_cnt_nxt = '0;
      end
    endcase
  end

  assign m0_ack = t_ack & ~sel_m1;
  assign m1_ack = t_ack &  sel_m1;
  assign m0_din = sel_m1 ? '0 : t_din;
  assign m1_din = sel_m1 ? t_din : '0;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: transaction-level reference model with randomized traffic.
module tb_bus_arbiter;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        m0_stb, m0_we, m1_stb, m1_we;
  logic [21:0] m0_addr, m1_addr;
  logic [31:0] m0_dout, m1_dout, m0_din, m1_din;
  logic        m0_ack, m1_ack;
  logic        bus_stb, bus_we, bus_ack, bus_err;
  logic [21:0] bus_addr;
  logic [31:0] bus_dout, bus_din;

  bus_arbiter #(.TO_CYCLES(TO), .TO_WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .m0_stb(m0_stb), .m0_we(m0_we), .m0_addr(m0_addr), .m0_dout(m0_dout),
    .m0_din(m0_din), .m0_ack(m0_ack),
    .m1_stb(m1_stb), .m1_we(m1_we), .m1_addr(m1_addr), .m1_dout(m1_dout),
    .m1_din(m1_din), .m1_ack(m1_ack),
    .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr), .bus_dout(bus_dout),
    .bus_din(bus_din), .bus_ack(bus_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit model_last;  // 1 = m1 granted last

  typedef struct {
    int          who;
    int          stb_delay;
    int          gcyc;
    logic [31:0] din;
    logic        err;
    logic [21:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic        idle_after;
    logic        stray;
    logic        done;
  } obs_t;

  function automatic int exp_winner(bit r0, bit r1);
    if (r0 && !r1) return 0;
    if (r1 && !r0) return 1;
`ifdef ARB_ROUND_ROBIN_EN
    return model_last ? 0 : 1;
`else
    return 1;
`endif
  endfunction

  function automatic int exp_gcyc(int lat);
    return (lat >= 1 && lat <= int'(TO)) ? lat : int'(TO);
  endfunction

  // Drives one request from IDLE; slave acks in granted cycle 'lat' (0 = never).
  task automatic txn(input bit r0, input bit r1, input int lat,
                     input logic [31:0] rdata, output obs_t o);
    int k;
    bit got;
    o = '{default: '0};
    o.who = -1;
    o.stb_delay = -1;
    m0_stb = r0;
    m1_stb = r1;
    bus_ack = 1'b0;
    bus_din = $urandom;
    k = 0;
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      if (n > 0) begin
        @(posedge clk); #1;
      end
      bus_ack = 1'b0;
      if (bus_stb) begin
        k++;
        if (k == 1) begin
          o.stb_delay = n;
          o.addr = bus_addr;
          o.we = bus_we;
          o.wdata = bus_dout;
        end
        if (k == lat) begin
          bus_ack = 1'b1;
          bus_din = rdata;
        end
      end
      @(negedge clk);
      if (m0_ack || m1_ack) begin
        got = 1;
        o.who = m1_ack ? 1 : 0;
        o.gcyc = k;
        o.din = m1_ack ? m1_din : m0_din;
        o.err = bus_err;
        if (m0_ack && m1_ack) o.stray = 1'b1;
        if ((m1_ack ? m0_din : m1_din) !== 32'h0) o.stray = 1'b1;
      end else begin
        if (bus_err) o.stray = 1'b1;
        if (!bus_stb && (m0_din !== 32'h0 || m1_din !== 32'h0)) o.stray = 1'b1;
      end
    end
    o.done = got;
    @(posedge clk); #1;
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    bus_ack = 1'b0;
    @(negedge clk);
    o.idle_after = !bus_stb && !m0_ack && !m1_ack;
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m0_stb = 1'b0;
    m1_stb = 1'b0;
    bus_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    m0_stb = 1'b1; m1_stb = 1'b1; m0_we = 1'b1; m1_we = 1'b1;
    m0_addr = 22'h155555; m1_addr = 22'h2AAAAA;
    m0_dout = 32'h11111111; m1_dout = 32'h22222222;
    bus_ack = 1'b1; bus_din = 32'hCAFEF00D;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    total++; if (bus_stb !== 1'b0) begin bad++; $display("FAIL reset_bus_stb got=%0b exp=0", bus_stb); end
    total++; if ({m1_ack, m0_ack} !== 2'b00) begin bad++; $display("FAIL reset_acks got=%b exp=00", {m1_ack, m0_ack}); end
    total++; if (m0_din !== 32'h0) begin bad++; $display("FAIL reset_m0_din got=%h exp=0", m0_din); end
    total++; if (m1_din !== 32'h0) begin bad++; $display("FAIL reset_m1_din got=%h exp=0", m1_din); end
    total++; if (bus_err !== 1'b0) begin bad++; $display("FAIL reset_bus_err got=%0b exp=0", bus_err); end
    do_reset();
  endtask

  task automatic test_single_read();
    obs_t o;
    m0_we = 1'b0; m0_addr = 22'h000100; m0_dout = 32'h0BADF00D;
    txn(1'b1, 1'b0, 3, 32'hDEADBEEF, o);
    total++; if (o.stb_delay !== 1) begin bad++; $display("FAIL single_stb_delay got=%0d exp=1", o.stb_delay); end
    total++; if (o.who !== 0) begin bad++; $display("FAIL single_who got=%0d exp=0", o.who); end
    total++; if (o.gcyc !== 3) begin bad++; $display("FAIL single_ack_cycle got=%0d exp=3", o.gcyc); end
    total++; if (o.din !== 32'hDEADBEEF) begin bad++; $display("FAIL single_din got=%h exp=deadbeef", o.din); end
    total++; if (o.addr !== 22'h000100) begin bad++; $display("FAIL single_addr got=%h exp=000100", o.addr); end
    total++; if (o.stray !== 1'b0) begin bad++; $display("FAIL single_stray got=%0b exp=0", o.stray); end
    model_last = 1'b0;
  endtask

  task automatic test_timeout();
    obs_t o;
    m1_we = 1'b1; m1_addr = 22'h3ABCDE; m1_dout = 32'h5A5A5A5A;
    txn(1'b0, 1'b1, 0, 32'h0, o);
    total++; if (o.who !== 1) begin bad++; $display("FAIL timeout_who got=%0d exp=1", o.who); end
    total++; if (o.gcyc !== int'(TO)) begin bad++; $display("FAIL timeout_cycle got=%0d exp=%0d", o.gcyc, TO); end
    total++; if (o.din !== 32'hFFFFFFFF) begin bad++; $display("FAIL timeout_din got=%h exp=ffffffff", o.din); end
    total++; if (o.err !== 1'b1) begin bad++; $display("FAIL timeout_err got=%0b exp=1", o.err); end
    total++; if ({o.we, o.wdata} !== {1'b1, 32'h5A5A5A5A}) begin bad++; $display("FAIL timeout_wr got=%0b/%h exp=1/5a5a5a5a", o.we, o.wdata); end
    total++; if (o.idle_after !== 1'b1) begin bad++; $display("FAIL timeout_idle got=%0b exp=1", o.idle_after); end
    model_last = 1'b1;
  endtask

  task automatic test_ack_at_expiry();
    obs_t o;
    m1_we = 1'b0; m1_addr = 22'h000777;
    txn(1'b0, 1'b1, int'(TO), 32'h12345678, o);
    total++; if (o.gcyc !== int'(TO)) begin bad++; $display("FAIL expiry_cycle got=%0d exp=%0d", o.gcyc, TO); end
    total++; if (o.din !== 32'h12345678) begin bad++; $display("FAIL expiry_din got=%h exp=12345678", o.din); end
    total++; if (o.err !== 1'b0) begin bad++; $display("FAIL expiry_err got=%0b exp=0", o.err); end
    model_last = 1'b1;
  endtask

  task automatic test_stb_drop();
    m0_stb = 1'b1; m1_stb = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (bus_stb !== 1'b1) begin bad++; $display("FAIL drop_granted got=%0b exp=1", bus_stb); end
    @(posedge clk); #1;
    m0_stb = 1'b0; bus_ack = 1'b1; bus_din = 32'h0F0F0F0F;
    @(negedge clk);
    total++; if ({bus_stb, m0_ack} !== 2'b00) begin bad++; $display("FAIL drop_no_ack got=%b exp=00", {bus_stb, m0_ack}); end
    @(posedge clk); #1;
    m0_stb = 1'b1;
    @(negedge clk);
    total++; if ({bus_stb, m0_ack} !== 2'b00) begin bad++; $display("FAIL drop_idle_ack_ignored got=%b exp=00", {bus_stb, m0_ack}); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if ({m0_ack, m0_din} !== {1'b1, 32'h0F0F0F0F}) begin bad++; $display("FAIL drop_regrant got=%0b/%h exp=1/0f0f0f0f", m0_ack, m0_din); end
    @(posedge clk); #1;
    m0_stb = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    model_last = 1'b0;
  endtask

  task automatic test_back_to_back();
    int w;
    logic [1:0] exp_ack;
    do_reset();
    m0_stb = 1'b1; m1_stb = 1'b1; bus_ack = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      bus_din = 32'hA5A50000 | c;
      @(negedge clk);
      exp_ack = 2'b00;
      w = -1;
      if (c % 2 == 1) begin
        w = exp_winner(1'b1, 1'b1);
        exp_ack = (w == 1) ? 2'b10 : 2'b01;
      end
      total++;
      if ({m1_ack, m0_ack} !== exp_ack) begin
        bad++; $display("FAIL b2b_grant cyc=%0d got=%b exp=%b", c, {m1_ack, m0_ack}, exp_ack);
      end
      total++;
      if (bus_stb !== (c % 2 == 1)) begin
        bad++; $display("FAIL b2b_spacing cyc=%0d got=%0b exp=%0b", c, bus_stb, (c % 2 == 1));
      end
      if (w >= 0) begin
        total++;
        if ((w == 1 ? m1_din : m0_din) !== (32'hA5A50000 | c)) begin
          bad++; $display("FAIL b2b_din cyc=%0d got=%h exp=%h", c, (w == 1 ? m1_din : m0_din), 32'hA5A50000 | c);
        end
        model_last = (w == 1);
      end
    end
    @(posedge clk); #1;
    m0_stb = 1'b0; m1_stb = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    do_reset();
    m0_stb = 1'b1; m0_addr = 22'h012345; bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b1;
    @(negedge clk);
    total++; if ({bus_stb, m0_ack} !== 2'b00) begin bad++; $display("FAIL rstmid_abort got=%b exp=00", {bus_stb, m0_ack}); end
    @(posedge clk); #1;
    bus_ack = 1'b1; bus_din = 32'h600DCAFE;
    @(negedge clk);
    total++; if ({bus_stb, bus_addr} !== {1'b1, 22'h012345}) begin bad++; $display("FAIL rstmid_regrant got=%0b/%h exp=1/012345", bus_stb, bus_addr); end
    total++; if ({m0_ack, m0_din} !== {1'b1, 32'h600DCAFE}) begin bad++; $display("FAIL rstmid_ack got=%0b/%h exp=1/600dcafe", m0_ack, m0_din); end
    @(posedge clk); #1;
    m0_stb = 1'b0; bus_ack = 1'b0;
    @(posedge clk); #1;
    model_last = 1'b0;
  endtask

  task automatic test_random();
    obs_t o;
    bit r0, r1;
    int lat, w, eg;
    logic [31:0] rdata, edin;
    for (int t = 0; t < 24; t++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r0 = 1'b1;
      lat = $urandom_range(1, 12);
      rdata = $urandom;
      m0_we = 1'($urandom); m0_addr = 22'($urandom); m0_dout = $urandom;
      m1_we = 1'($urandom); m1_addr = 22'($urandom); m1_dout = $urandom;
      w = exp_winner(r0, r1);
      eg = exp_gcyc(lat);
      edin = (lat <= int'(TO)) ? rdata : 32'hFFFFFFFF;
      txn(r0, r1, lat, rdata, o);
      total++; if (o.who !== w) begin bad++; $display("FAIL rnd_who t=%0d got=%0d exp=%0d", t, o.who, w); end
      total++; if (o.stb_delay !== 1) begin bad++; $display("FAIL rnd_latency t=%0d got=%0d exp=1", t, o.stb_delay); end
      total++; if (o.gcyc !== eg) begin bad++; $display("FAIL rnd_ack_cycle t=%0d got=%0d exp=%0d", t, o.gcyc, eg); end
      total++; if (o.din !== edin) begin bad++; $display("FAIL rnd_din t=%0d got=%h exp=%h", t, o.din, edin); end
      total++; if (o.err !== (lat > int'(TO))) begin bad++; $display("FAIL rnd_err t=%0d got=%0b exp=%0b", t, o.err, lat > int'(TO)); end
      total++;
      if ({o.we, o.addr, o.wdata} !== (w == 1 ? {m1_we, m1_addr, m1_dout} : {m0_we, m0_addr, m0_dout})) begin
        bad++; $display("FAIL rnd_passthru t=%0d got=%0b/%h/%h", t, o.we, o.addr, o.wdata);
      end
      total++; if ({o.stray, o.idle_after} !== 2'b01) begin bad++; $display("FAIL rnd_hygiene t=%0d got=%b exp=01", t, {o.stray, o.idle_after}); end
      model_last = (w == 1);
    end
  endtask

  initial begin
    rst = 1'b1;
    m0_stb = 1'b0; m1_stb = 1'b0; m0_we = 1'b0; m1_we = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_dout = '0; m1_dout = '0;
    bus_ack = 1'b0; bus_din = '0;
    test_reset();
    test_single_read();
    test_timeout();
    test_ack_at_expiry();
    test_stb_drop();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
